// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and datapath widths for the multiplier sequencer.
package mult_pkg;
    localparam int OP_W = 4;
    localparam int PROD_W = 8;
    typedef enum logic [2:0] {RST_MUL, IDLE, ISSUE, WAIT_RISE, WAIT_FALL, SETTLE, CAPTURE, OUT} state_e;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr_q, sr_d;
    always_comb sr_d = {sr_q[STAGES-2:0], d};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end
    assign q = sr_q[STAGES-1];
endmodule

// File: rtl/mult_op_sequencer.sv
// mult_op_sequencer: valid/ready front end for the self-timed 4x4 multiplier with per-phase timeout.
// Define MULT_SEQ_ACC_EN to add the 16-bit product accumulator (acc_clr / out_acc).
module mult_op_sequencer
    import mult_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
`ifdef MULT_SEQ_ACC_EN
    input  logic              acc_clr,
    output logic [15:0]       out_acc,
`endif
    output logic              mul_reset,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_finish,
    input  logic [PROD_W-1:0] mul_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic              out_err,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              err_q, err_d, start_q, start_d, mreset_q, mreset_d, busy_q, busy_d;
    logic              fin_s, tmo;
`ifdef MULT_SEQ_ACC_EN
    logic [15:0]       acc_q, acc_d;
`endif

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(reset),
        .d  (mul_finish),
        .q  (fin_s)
    );

    assign tmo = timer_q == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
`ifdef MULT_SEQ_ACC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            RST_MUL: state_d = err_q ? OUT : IDLE;
            IDLE: if (in_valid) begin
                state_d = ISSUE;
                a_d     = in_a;
                b_d     = in_b;
                timer_d = '0;
`ifdef MULT_SEQ_ACC_EN
                if (acc_clr) acc_d = '0;
`endif
            end
            ISSUE: begin
                state_d = WAIT_RISE;
                timer_d = '0;
            end
            WAIT_RISE: if (fin_s) begin
                state_d = WAIT_FALL;
                timer_d = '0;
            end else if (tmo) begin
                state_d = RST_MUL;
                prod_d  = '0;
                err_d   = 1'b1;
            end else timer_d = timer_q + 1'b1;
            // product register only settles once finish has fallen
            WAIT_FALL: if (!fin_s) state_d = SETTLE;
            else if (tmo) begin
                state_d = RST_MUL;
                prod_d  = '0;
                err_d   = 1'b1;
            end else timer_d = timer_q + 1'b1;
            SETTLE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = OUT;
                prod_d  = mul_o;
                err_d   = 1'b0;
`ifdef MULT_SEQ_ACC_EN
                acc_d   = acc_q + 16'(mul_o);
`endif
            end
            OUT: if (out_ready) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = RST_MUL;
        endcase
        start_d  = state_d == ISSUE || state_d == WAIT_RISE;
        mreset_d = state_d == RST_MUL;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST_MUL;
            timer_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            mreset_q <= 1'b1;
            busy_q   <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
            start_q  <= start_d;
            mreset_q <= mreset_d;
            busy_q   <= busy_d;
`ifdef MULT_SEQ_ACC_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign mul_reset = mreset_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_prod  = prod_q;
    assign out_err   = err_q;
    assign busy      = busy_q;
`ifdef MULT_SEQ_ACC_EN
    assign out_acc   = acc_q;
`endif
endmodule

// File: tb/tb_mult_op_sequencer.sv
// tb_mult_op_sequencer: randomized ops against a behavioural self-timed multiplier and a product/accumulator model.
module tb_mult_op_sequencer;
    localparam int TIMEOUT_CYC = 64;

    logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, mul_finish = 1'b0;
    logic [3:0] in_a = '0, in_b = '0;
    logic [7:0] mul_o = '0;
    logic       in_ready, mul_reset, mul_start, out_valid, out_err, busy;
    logic [3:0] mul_a, mul_b;
    logic [7:0] out_prod;
`ifdef MULT_SEQ_ACC_EN
    logic        acc_clr = 1'b0;
    logic [15:0] out_acc;
`endif

    int          n_checks = 0, n_fail = 0;
    bit          hang = 1'b0;
    int          fall_lo = 3, fall_hi = 40;
    logic [15:0] acc_model = '0;

    mult_op_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef MULT_SEQ_ACC_EN
        .acc_clr(acc_clr), .out_acc(out_acc),
`endif
        .mul_reset(mul_reset), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_finish(mul_finish), .mul_o(mul_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // self-timed multiplier: finish rises some time after start, falls after start drops, product lands with the fall
    always begin
        @(posedge mul_start);
        if (!hang) begin
            #($urandom_range(80, 3));
            mul_finish = 1'b1;
            @(negedge mul_start);
            #($urandom_range(fall_hi, fall_lo));
            mul_o      = {4'b0, mul_a} * {4'b0, mul_b};
            mul_finish = 1'b0;
        end
    end
    always @(posedge mul_reset) mul_finish = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit clr, input bit exp_err, input int bp);
        logic [7:0] exp_prod, held;
        int         start_cyc;
        bit         saw_mr, got, stable;
        exp_prod  = exp_err ? 8'd0 : {4'b0, a} * {4'b0, b};
        if (clr) acc_model = '0;
        if (!exp_err) acc_model = acc_model + {8'b0, exp_prod};
        saw_mr = 1'b0; got = 1'b0; stable = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b;
`ifdef MULT_SEQ_ACC_EN
        acc_clr = clr;
`endif
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check("in_ready_wait", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 4'($urandom); in_b = 4'($urandom);
`ifdef MULT_SEQ_ACC_EN
        acc_clr = 1'($urandom);
`endif
        @(negedge clk);
        check("issue_start", 32'(mul_start), 1);
        check("issue_in_ready", 32'(in_ready), 0);
        start_cyc = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            start_cyc += int'(mul_start);
            saw_mr |= mul_reset;
        end
        check("out_valid_seen", 32'(got), 1);
        if (!got) return;
        check("out_prod", 32'(out_prod), 32'(exp_prod));
        check("out_err", 32'(out_err), 32'(exp_err));
        check("mul_a_held", 32'(mul_a), 32'(a));
        check("mul_b_held", 32'(mul_b), 32'(b));
        check("out_in_ready", 32'(in_ready), 0);
        check("mul_reset_pulse", 32'(saw_mr), 32'(exp_err));
        if (exp_err) check("start_cycles", 32'(start_cyc), 32'(TIMEOUT_CYC + 1));
`ifdef MULT_SEQ_ACC_EN
        check("out_acc", 32'(out_acc), 32'(acc_model));
`endif
        held = out_prod;
        repeat (bp) begin
            @(negedge clk);
            if (!out_valid || out_prod !== held || in_ready) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("accept_valid", 32'(out_valid), 0);
        check("accept_idle", 32'(in_ready), 1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_mul_reset", 32'(mul_reset), 1);
        check("rel_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        check("post_mul_reset", 32'(mul_reset), 0);
        check("post_in_ready", 32'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mul_start"}, 32'(mul_start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ops"}, {24'b0, mul_a, mul_b}, 0);
        check({tag, "_out_prod"}, 32'(out_prod), 0);
        check({tag, "_out_err"}, 32'(out_err), 0);
        check({tag, "_mul_reset"}, 32'(mul_reset), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_reset();
        do_op(4'd15, 4'd15, 1'b0, 1'b0, 0);
        do_op(4'd15, 4'd15, 1'b0, 1'b0, 0);
        do_op(4'd3,  4'd2,  1'b0, 1'b0, 0);
        do_op(4'd2,  4'd2,  1'b1, 1'b0, 0);
        do_op(4'd13, 4'd11, 1'b0, 1'b0, 0);
        do_op(4'd0,  4'd15, 1'b0, 1'b0, 0);
        do_op(4'd1,  4'd1,  1'b0, 1'b0, 0);
        do_op(4'd15, 4'd15, 1'b0, 1'b0, 20);
        hang = 1'b1;
        do_op(4'd5, 4'd6, 1'b0, 1'b1, 2);
        hang = 1'b0;
        do_op(4'd9, 4'd9, 1'b0, 1'b0, 0);
        // hold finish high long enough to catch the sequencer in its fall-wait phase
        fall_lo = 150; fall_hi = 150;
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 200 && mul_start; i++) @(negedge clk);
        check("midop_busy", 32'(busy), 1);
        check("midop_start_low", 32'(mul_start), 0);
        check("midop_finish_high", 32'(mul_finish), 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midop");
        acc_model = '0;
        repeat (2) @(negedge clk);
        release_reset();
        repeat (20) @(negedge clk);
        fall_lo = 3; fall_hi = 40;
        for (int k = 0; k < 12; k++)
            do_op(4'($urandom), 4'($urandom), 1'($urandom_range(3, 0) == 0), 1'b0, int'($urandom_range(3, 0)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
